// File: rtl/sa_skew_feeder.sv
// Skewing front-end for the SA systolic array: takes un-skewed K-slices over valid/ready,
// delays row lane i by i and column lane j by j cycles, and sequences clear/enable/drain/done.
module sa_skew_feeder #(
    parameter int ROW_NUM = 32,
    parameter int COL_NUM = 32,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 16,
    parameter int K_MAX   = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           cfg_mode,
    input  logic [$clog2(K_MAX+1)-1:0]     cfg_k,
    input  logic [$clog2(ROW_NUM+1)-1:0]   cfg_rows,
    input  logic [$clog2(COL_NUM+1)-1:0]   cfg_cols,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROW_NUM*ROW_W-1:0]       in_row,
    input  logic [COL_NUM*COL_W-1:0]       in_col,
    output logic [ROW_NUM*ROW_W-1:0]       sa_row_in,
    output logic [COL_NUM*COL_W-1:0]       sa_column_in,
    output logic                           sa_en,
    output logic                           sa_clr,
    output logic                           sa_mode,
    output logic                           busy,
    output logic                           tile_done
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = $clog2(ROW_NUM + 1);
    localparam int CW = $clog2(COL_NUM + 1);
    localparam int DW = $clog2(ROW_NUM + COL_NUM);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_clamp, k_last_q, beat_cnt;
    logic [RW-1:0]   rows_clamp, rows_q;
    logic [CW-1:0]   cols_clamp, cols_q;
    logic [DW-1:0]   drain_last_q, drain_cnt;
    logic            mode_q;
    logic            abort_hit, start_go, accept, push, flush;

    always_comb begin
        k_clamp    = cfg_k;
        rows_clamp = cfg_rows;
        cols_clamp = cfg_cols;
        if (cfg_k > KW'(K_MAX))
            k_clamp = KW'(K_MAX);
        if (cfg_rows == '0)
            rows_clamp = RW'(1);
        else if (cfg_rows > RW'(ROW_NUM))
            rows_clamp = RW'(ROW_NUM);
        if (cfg_cols == '0)
            cols_clamp = CW'(1);
        else if (cfg_cols > CW'(COL_NUM))
            cols_clamp = CW'(COL_NUM);
    end

    assign abort_hit = abort && (state_q != IDLE);
    assign start_go  = start && !abort && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    // A push advances every skew chain by one stage; stalls in FEED freeze them.
    assign push      = (accept || (state_q == DRAIN)) && !abort_hit;
    assign flush     = (state_q == CLEAR) || abort_hit;

    assign in_ready  = (state_q == FEED);
    assign sa_clr    = (state_q == CLEAR);
    assign busy      = (state_q != IDLE);
    assign sa_mode   = mode_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_go) state_d = (k_clamp == '0) ? DONE : CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (accept && (beat_cnt == k_last_q)) state_d = DRAIN;
            DRAIN:   if (drain_cnt == drain_last_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit)
            state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            k_last_q     <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            drain_last_q <= '0;
            beat_cnt     <= '0;
            drain_cnt    <= '0;
            sa_en        <= 1'b0;
            tile_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_en     <= push;
            tile_done <= (state_q == DONE) && !abort_hit;
            if (abort_hit) begin
                beat_cnt  <= '0;
                drain_cnt <= '0;
            end else begin
                if (start_go) begin
                    mode_q       <= cfg_mode;
                    k_last_q     <= k_clamp - KW'(1);
                    rows_q       <= rows_clamp;
                    cols_q       <= cols_clamp;
                    drain_last_q <= DW'(rows_clamp) + DW'(cols_clamp) - DW'(2);
                    beat_cnt     <= '0;
                    drain_cnt    <= '0;
                end
                if (accept)
                    beat_cnt <= beat_cnt + KW'(1);
                if (state_q == DRAIN)
                    drain_cnt <= drain_cnt + DW'(1);
            end
        end
    end

    // Row lane i: i+1 stages; inactive lanes and drain pushes feed zeros.
    for (genvar i = 0; i < ROW_NUM; i++) begin : g_row
        logic [ROW_W-1:0] stage [0:i];
        logic [ROW_W-1:0] lane_in;

        assign lane_in = (accept && (int'(rows_q) > i)) ? in_row[i*ROW_W +: ROW_W] : '0;

        // NOTE: the skew stages drive the array directly, so they are reset rather than left unknown.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= i; s++) stage[s] <= '0;
            end else if (flush) begin
                for (int s = 0; s <= i; s++) stage[s] <= '0;
            end else if (push) begin
                stage[0] <= lane_in;
                for (int s = 1; s <= i; s++) stage[s] <= stage[s-1];
            end
        end

        assign sa_row_in[i*ROW_W +: ROW_W] = stage[i];
    end

    for (genvar j = 0; j < COL_NUM; j++) begin : g_col
        logic [COL_W-1:0] stage [0:j];
        logic [COL_W-1:0] lane_in;

        assign lane_in = (accept && (int'(cols_q) > j)) ? in_col[j*COL_W +: COL_W] : '0;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= j; s++) stage[s] <= '0;
            end else if (flush) begin
                for (int s = 0; s <= j; s++) stage[s] <= '0;
            end else if (push) begin
                stage[0] <= lane_in;
                for (int s = 1; s <= j; s++) stage[s] <= stage[s-1];
            end
        end

        assign sa_column_in[j*COL_W +: COL_W] = stage[j];
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: cycle tables for the 2x2 tile (plain and stalled)
// plus hand sequences for masking, K clamping, K=0, abort and asynchronous reset.
module tb_sa_skew_feeder;

    localparam int RN = 32;
    localparam int CN = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start, abort, cfg_mode, in_valid;
    logic [6:0]     cfg_k;
    logic [5:0]     cfg_rows, cfg_cols;
    logic [RN*8-1:0]  in_row;
    logic [CN*16-1:0] in_col;
    logic           in_ready, sa_en, sa_clr, sa_mode, busy, tile_done;
    logic [RN*8-1:0]  sa_row_in;
    logic [CN*16-1:0] sa_column_in;

    int n_cmp = 0;
    int n_bad = 0;

    sa_skew_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .cfg_mode     (cfg_mode),
        .cfg_k        (cfg_k),
        .cfg_rows     (cfg_rows),
        .cfg_cols     (cfg_cols),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .in_col       (in_col),
        .sa_row_in    (sa_row_in),
        .sa_column_in (sa_column_in),
        .sa_en        (sa_en),
        .sa_clr       (sa_clr),
        .sa_mode      (sa_mode),
        .busy         (busy),
        .tile_done    (tile_done)
    );

    always #5 clk = ~clk;

    // One cycle record: inputs driven in this cycle, outputs expected in this cycle.
    typedef struct {
        logic        st, vld;
        logic [7:0]  r0, r1;
        logic [15:0] c0, c1;
        logic        e_clr, e_rdy, e_en, e_done, e_busy;
        logic [7:0]  er0, er1;
        logic [15:0] ec0, ec1;
    } vec_t;

    vec_t vecs [0:20];

    function automatic vec_t mk(input logic st, vld, input logic [7:0] r0, r1,
                                input logic [15:0] c0, c1,
                                input logic e_clr, e_rdy, e_en, e_done, e_busy,
                                input logic [7:0] er0, er1, input logic [15:0] ec0, ec1);
        vec_t v;
        v.st = st; v.vld = vld; v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1;
        v.e_clr = e_clr; v.e_rdy = e_rdy; v.e_en = e_en; v.e_done = e_done; v.e_busy = e_busy;
        v.er0 = er0; v.er1 = er1; v.ec0 = ec0; v.ec1 = ec1;
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [6:0] k, input logic [5:0] rows, cols, input logic mode);
        cfg_k = k; cfg_rows = rows; cfg_cols = cols; cfg_mode = mode;
    endtask

    task automatic apply_vecs(input string tag, input int first, input int count);
        logic [RN*8-1:0]  er;
        logic [CN*16-1:0] ec;
        for (int i = first; i < first + count; i++) begin
            er = '0; er[7:0] = vecs[i].er0; er[15:8] = vecs[i].er1;
            ec = '0; ec[15:0] = vecs[i].ec0; ec[31:16] = vecs[i].ec1;
            check($sformatf("%s[%0d].clr",  tag, i - first), sa_clr,    vecs[i].e_clr);
            check($sformatf("%s[%0d].rdy",  tag, i - first), in_ready,  vecs[i].e_rdy);
            check($sformatf("%s[%0d].en",   tag, i - first), sa_en,     vecs[i].e_en);
            check($sformatf("%s[%0d].done", tag, i - first), tile_done, vecs[i].e_done);
            check($sformatf("%s[%0d].busy", tag, i - first), busy,      vecs[i].e_busy);
            check($sformatf("%s[%0d].row",  tag, i - first), sa_row_in, er);
            check($sformatf("%s[%0d].col",  tag, i - first), sa_column_in, ec);
            start    = vecs[i].st;
            in_valid = vecs[i].vld;
            in_row   = '0; in_row[7:0] = vecs[i].r0; in_row[15:8] = vecs[i].r1;
            in_col   = '0; in_col[15:0] = vecs[i].c0; in_col[31:16] = vecs[i].c1;
            tick();
        end
        start = 1'b0; in_valid = 1'b0; in_row = '0; in_col = '0;
    endtask

    // Runs a whole tile with in_valid held high; counts events until tile_done (bounded).
    task automatic run_tile(input logic [6:0] k, input logic [5:0] rows, cols, input logic mode,
                            output int n_acc, n_en, n_clr, done_at, output logic mask_ok);
        int cyc;
        n_acc = 0; n_en = 0; n_clr = 0; done_at = -1; mask_ok = 1'b1;
        set_cfg(k, rows, cols, mode);
        for (int i = 0; i < RN; i++) in_row[i*8 +: 8] = 8'hFF;
        for (int j = 0; j < CN; j++) in_col[j*16 +: 16] = 16'hABCD;
        in_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done_at < 0 && cyc < 300) begin
            if (in_ready) n_acc++;
            if (sa_en) n_en++;
            if (sa_clr) n_clr++;
            if (tile_done) done_at = cyc;
            for (int i = int'(rows); i < RN; i++)
                if (sa_row_in[i*8 +: 8] != 8'h00) mask_ok = 1'b0;
            for (int j = int'(cols); j < CN; j++)
                if (sa_column_in[j*16 +: 16] != 16'h0000) mask_ok = 1'b0;
            tick();
            cyc++;
        end
        in_valid = 1'b0; in_row = '0; in_col = '0;
    endtask

    initial begin
        int   n_acc, n_en, n_clr, done_at, seen;
        logic mask_ok;

        // Basic 2x2, K=2 tile.
        vecs[0]  = mk(1,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,0,0,0, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[1]  = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 1,0,0,0,1, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[2]  = mk(0,1, 8'h01,8'h02,16'h0010,16'h0020, 0,1,0,0,1, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[3]  = mk(0,1, 8'h03,8'h04,16'h0030,16'h0040, 0,1,1,0,1, 8'h01,8'h00,16'h0010,16'h0000);
        vecs[4]  = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,1,0,1, 8'h03,8'h02,16'h0030,16'h0020);
        vecs[5]  = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,1,0,1, 8'h00,8'h04,16'h0000,16'h0040);
        vecs[6]  = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,1,0,1, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[7]  = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,1,0,1, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[8]  = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,0,1,0, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[9]  = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,0,0,0, 8'h00,8'h00,16'h0000,16'h0000);
        // Same tile with a one-cycle bubble between the beats.
        vecs[10] = mk(1,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,0,0,0, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[11] = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 1,0,0,0,1, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[12] = mk(0,1, 8'h01,8'h02,16'h0010,16'h0020, 0,1,0,0,1, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[13] = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,1,1,0,1, 8'h01,8'h00,16'h0010,16'h0000);
        vecs[14] = mk(0,1, 8'h03,8'h04,16'h0030,16'h0040, 0,1,0,0,1, 8'h01,8'h00,16'h0010,16'h0000);
        vecs[15] = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,1,0,1, 8'h03,8'h02,16'h0030,16'h0020);
        vecs[16] = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,1,0,1, 8'h00,8'h04,16'h0000,16'h0040);
        vecs[17] = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,1,0,1, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[18] = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,1,0,1, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[19] = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,0,1,0, 8'h00,8'h00,16'h0000,16'h0000);
        vecs[20] = mk(0,0, 8'h00,8'h00,16'h0000,16'h0000, 0,0,0,0,0, 8'h00,8'h00,16'h0000,16'h0000);

        reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_row = '0; in_col = '0;
        set_cfg(7'd2, 6'd2, 6'd2, 1'b0);
        #2;
        check("reset.busy",  busy,      1'b0);
        check("reset.rdy",   in_ready,  1'b0);
        check("reset.en",    sa_en,     1'b0);
        check("reset.clr",   sa_clr,    1'b0);
        check("reset.done",  tile_done, 1'b0);
        check("reset.mode",  sa_mode,   1'b0);
        check("reset.row",   sa_row_in, '0);
        check("reset.col",   sa_column_in, '0);
        tick(); tick();
        reset = 1'b1;
        tick();

        apply_vecs("basic", 0, 10);
        apply_vecs("stall", 10, 11);

        run_tile(7'd3, 6'd1, 6'd3, 1'b0, n_acc, n_en, n_clr, done_at, mask_ok);
        check("mask.accepts", n_acc, 3);
        check("mask.en_total", n_en, 6);
        check("mask.lanes_zero", mask_ok, 1'b1);
        check("mask.done_at", done_at, 9);
        tick();

        run_tile(7'd65, 6'd1, 6'd1, 1'b0, n_acc, n_en, n_clr, done_at, mask_ok);
        check("kclamp.accepts", n_acc, 64);
        check("kclamp.en_total", n_en, 65);
        check("kclamp.done_at", done_at, 68);
        tick();

        run_tile(7'd0, 6'd2, 6'd2, 1'b1, n_acc, n_en, n_clr, done_at, mask_ok);
        check("k0.accepts", n_acc, 0);
        check("k0.en_total", n_en, 0);
        check("k0.clr_total", n_clr, 0);
        check("k0.done_at", done_at, 2);
        check("k0.mode", sa_mode, 1'b1);
        check("k0.busy_after", busy, 1'b0);
        tick();

        // Abort in the first DRAIN cycle.
        set_cfg(7'd2, 6'd2, 6'd2, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1; in_row[7:0] = 8'h01; in_row[15:8] = 8'h02;
        in_col[15:0] = 16'h0010; in_col[31:16] = 16'h0020; tick();
        in_row[7:0] = 8'h03; in_row[15:8] = 8'h04;
        in_col[15:0] = 16'h0030; in_col[31:16] = 16'h0040; tick();
        in_valid = 1'b0; in_row = '0; in_col = '0;
        check("abort.in_drain", {busy, in_ready}, 2'b10);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort.busy", busy, 1'b0);
        check("abort.en", sa_en, 1'b0);
        check("abort.row", sa_row_in, '0);
        check("abort.col", sa_column_in, '0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (tile_done) seen++;
            tick();
        end
        check("abort.no_done", seen, 0);

        // Asynchronous reset in the middle of FEED.
        set_cfg(7'd4, 6'd2, 6'd2, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1; in_row[7:0] = 8'h11; in_row[15:8] = 8'h12;
        in_col[15:0] = 16'h0111; in_col[31:16] = 16'h0112; tick();
        in_row[7:0] = 8'h21; in_row[15:8] = 8'h22; tick();
        check("rstmid.pre_en", sa_en, 1'b1);
        reset = 1'b0;
        #1;
        check("rstmid.busy", busy, 1'b0);
        check("rstmid.rdy",  in_ready, 1'b0);
        check("rstmid.en",   sa_en, 1'b0);
        check("rstmid.mode", sa_mode, 1'b0);
        check("rstmid.row",  sa_row_in, '0);
        check("rstmid.col",  sa_column_in, '0);
        in_valid = 1'b0; in_row = '0; in_col = '0;
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (tile_done || busy) seen++;
            tick();
        end
        check("rstmid.quiet", seen, 0);
        set_cfg(7'd2, 6'd2, 6'd2, 1'b0);
        apply_vecs("after_rst", 0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Parametrised front-end for the SA systolic array. Accepts one un-skewed K-slice per beat: a full weight/row vector and a full pixel/column vector, over a valid/ready handshake.
- Applies diagonal skew: row lane i and column lane j are delayed by i and j cycles respectively.
- Sequences the array's control: MAC clear, enable, drain flush and tile-done.
- Replaces hand-built zero-padded skewed flows. Generalises to any active rows/cols and any K depth, with stall handling, which the fixed array-plus-driver setup does not have.

Parameters:
- ROW_NUM, 32, physical array rows (row lanes).
- COL_NUM, 32, physical array columns (column lanes).
- ROW_W, 8, bits per row-lane element.
- COL_W, 16, bits per column-lane element.
- K_MAX, 64, maximum slices per tile.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  tile start pulse; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE.
- cfg_mode  in  1  0 = 8x8 mode, 1 = 1x8 mode; latched at start.
- cfg_k  in  clog2(K_MAX+1)  slices in the tile.
- cfg_rows  in  clog2(ROW_NUM+1)  active rows.
- cfg_cols  in  clog2(COL_NUM+1)  active columns.
- in_valid  in  1  slice beat valid.
- in_ready  out  1  slice beat accepted when in_valid & in_ready.
- in_row  in  ROW_NUM*ROW_W  slice row vector, lane i at [i*ROW_W +: ROW_W].
- in_col  in  COL_NUM*COL_W  slice column vector, lane j at [j*COL_W +: COL_W].
- sa_row_in  out  ROW_NUM*ROW_W  skewed rows to SA row_in.
- sa_column_in  out  COL_NUM*COL_W  skewed columns to SA column_in.
- sa_en  out  1  SA enable.
- sa_clr  out  1  SA MAC reset.
- sa_mode  out  1  latched mode to SA.
- busy  out  1  high in any state other than IDLE.
- tile_done  out  1  one-cycle pulse at tile end.

Behaviour:
- Reset (reset=0, async): state goes to IDLE. All skew registers, sa_row_in, sa_column_in, sa_en, sa_clr, sa_mode, busy, tile_done and in_ready are 0, counters are 0. Reset mid-tile discards the tile with no tile_done.
- States are IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 latches cfg_*, then goes to CLEAR.
  - cfg_rows and cfg_cols are clamped to [1, max]. cfg_k > K_MAX is clamped to K_MAX.
  - cfg_k=0 goes to DONE instead, with no sa_en.
- CLEAR: exactly one cycle. sa_clr=1, skew registers are zeroed. Next state is FEED.
- FEED:
  - in_ready=1.
  - Each accepted beat pushes in_row/in_col into the skew chains and increments the beat counter.
  - A cycle with no accepted beat freezes the chains (outputs hold) and gives sa_en=0 on the matching output cycle.
  - After the cfg_k-th accept, go to DRAIN.
- DRAIN:
  - in_ready=0.
  - Pushes all-zero slices for exactly cfg_rows+cfg_cols-1 cycles, then goes to DONE.
- DONE: one cycle, then IDLE.
- tile_done pulses in the cycle after the last sa_en=1 cycle.
- Skew chains:
  - Row lane i has i+1 registers; column lane j has j+1 registers.
  - An element accepted at cycle t appears on lane i of sa_row_in at t+1+i, counting only advancing cycles.
- sa_en is registered. It is high exactly on the output cycles of advancing pushes (FEED accepts and DRAIN pushes).
  - Unstalled tile: sa_en is contiguous for cfg_k+cfg_rows+cfg_cols-1 cycles.
- Inactive lanes (i >= cfg_rows, j >= cfg_cols) are forced to 0 at chain input for the whole tile.
- sa_mode holds the latched mode from CLEAR through DONE, and keeps it in IDLE until the next start.
- abort in any non-IDLE state: next cycle goes to IDLE with chains zeroed, sa_en=0, no tile_done. abort has priority over start.
- start outside IDLE is ignored.
- in_valid outside FEED is ignored (no accept).

Test Plan:
- Basic 2x2 tile:
  - Stimulus: cfg_rows=2, cfg_cols=2, cfg_k=2. Beat0 row={0x01,0x02}, col={0x0010,0x0020}. Beat1 row={0x03,0x04}, col={0x0030,0x0040}. Accepted at F0 and F0+1.
  - Rows at F0+1: lane0=0x01, lane1=0x00. At F0+2: lane0=0x03, lane1=0x02. At F0+3: lane0=0x00, lane1=0x04.
  - Columns follow the same pattern.
  - sa_en=1 for F0+1..F0+5; tile_done at F0+6; sa_clr high one cycle before F0.
- Stall: same tile with in_valid=0 for one cycle between the beats -> that output cycle has sa_en=0 and sa_row_in held. sa_en total stays 5; tile_done is delayed one cycle.
- Lane masking: cfg_rows=1, cfg_cols=3, in_row all lanes 0xFF -> lanes 1..31 of sa_row_in stay 0. Drain is 3 cycles; sa_en total is cfg_k+3.
- Mode and edge cases:
  - cfg_mode=1, cfg_k=0 -> CLEAR is skipped, sa_en never high, tile_done one cycle after start, sa_mode=1.
  - cfg_k=65 with K_MAX=64 -> exactly 64 beats accepted.
- Abort and reset:
  - abort during DRAIN -> IDLE next cycle, no tile_done, outputs 0.
  - reset low mid-FEED -> all outputs 0 immediately (asynchronous). After release, a new start runs a clean tile.
